pipelined_adder: RTL

- Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake on both sides.
- Splits a WIDTH-bit add into STAGES registered slices. Each slice resolves WIDTH/STAGES bits and passes its carry to the next slice one cycle later.
- Sits in the arithmetic datapath wherever a single-cycle adder of full width would limit clock rate.

---
 rtl/pipelined_adder_pkg.sv | 20 ++
 rtl/pipelined_adder_slice.sv | 31 +++
 rtl/pipelined_adder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared arithmetic helpers for the pipelined adder: operation encoding,
// slice-width derivation and configuration legality.
package pipelined_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic bit cfg_legal(input int width, input int stages);
    return (stages >= 1) && (width >= 2) && ((width % stages) == 0);
  endfunction

  // Guarded so an illegal STAGES value cannot divide by zero before the
  // elaboration check reports it.
  function automatic int slice_width(input int width, input int stages);
    return (stages >= 1) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational W-bit ripple-carry slice; also exposes the carry into its MSB
// so the final slice can derive signed overflow.
module adder_slice
  import pipelined_adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         msb_cin
);

  logic [W:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout    = c[W];
  assign msb_cin = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES registered slices of
// WIDTH/STAGES bits each, with a global stall driven by the output handshake.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int S = slice_width(WIDTH, STAGES);

  if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_check
    $fatal(1, "pipelined_adder: need WIDTH >= 2, STAGES >= 1, WIDTH divisible by STAGES");
  end

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             stall;

  assign op       = op_e'(sub);
  assign b_eff    = (op == OP_SUB) ? ~B : B;
  assign c0       = (op == OP_SUB) ? ~Cin : Cin;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Stage gi owns result bits [gi*S +: S]; operand bits not yet consumed ride
  // along in g_fwd, completed low sum bits accumulate in sum_q.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int  LO     = gi * S;
    localparam int  IN_W   = WIDTH - LO;
    localparam int  DONE_W = LO + S;
    localparam bit  LAST   = (gi == STAGES - 1);

    logic              v_in;
    logic              load;
    logic [IN_W-1:0]   a_in;
    logic [IN_W-1:0]   b_in;
    logic              cin_in;
    logic [DONE_W-1:0] sum_new;
    logic [S-1:0]      sl_s;
    logic              sl_cout;
    logic              sl_msbc;

    logic              valid_q, valid_d;
    logic              carry_q, carry_d;
    logic [DONE_W-1:0] sum_q, sum_d;

    if (gi == 0) begin : g_src
      assign v_in    = in_valid;
      assign a_in    = A;
      assign b_in    = b_eff;
      assign cin_in  = c0;
      assign sum_new = sl_s;
    end else begin : g_src
      assign v_in    = g_stage[gi-1].valid_q;
      assign a_in    = g_stage[gi-1].g_fwd.a_fwd_q;
      assign b_in    = g_stage[gi-1].g_fwd.b_fwd_q;
      assign cin_in  = g_stage[gi-1].carry_q;
      assign sum_new = {sl_s, g_stage[gi-1].sum_q};
    end

    // Data registers only load on a real beat so the outputs keep their last
    // result across bubbles.
    assign load = !stall && v_in;

    adder_slice #(
      .W (S)
    ) u_slice (
      .a       (a_in[S-1:0]),
      .b       (b_in[S-1:0]),
      .cin     (cin_in),
      .s       (sl_s),
      .cout    (sl_cout),
      .msb_cin (sl_msbc)
    );

    always_comb begin
      valid_d = stall ? valid_q : v_in;
      sum_d   = load ? sum_new : sum_q;
      carry_d = load ? sl_cout : carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (!LAST) begin : g_fwd
      logic [IN_W-S-1:0] a_fwd_q, a_fwd_d;
      logic [IN_W-S-1:0] b_fwd_q, b_fwd_d;
      logic              msbc_unused;

      assign msbc_unused = sl_msbc;

      always_comb begin
        a_fwd_d = load ? a_in[IN_W-1:S] : a_fwd_q;
        b_fwd_d = load ? b_in[IN_W-1:S] : b_fwd_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_fwd_q <= '0;
          b_fwd_q <= '0;
        end else begin
          a_fwd_q <= a_fwd_d;
          b_fwd_q <= b_fwd_d;
        end
      end
    end else begin : g_ovf
      logic ovf_q, ovf_d;

      always_comb begin
        ovf_d = load ? (sl_msbc ^ sl_cout) : ovf_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign carry     = g_stage[STAGES-1].carry_q;
  assign overflow  = g_stage[STAGES-1].g_ovf.ovf_q;

endmodule
